countdown_pair: RTL and testbench

- Down-counting counterpart of the team's up-counter invariant example, with states kept in complementary form.
- Explicit (ILA-modelled) state `v` counts down from a loaded value to zero.
- Implicit micro-arch state `imp` counts up in lockstep.
- Required invariant: v == MAX - imp.
- `out` is computed through both registers, so it equals `v` only while the invariant holds. The block is a target for CEGAR invariant synthesis and a load/run/done handshake unit.

---
 rtl/countdown_pair_pkg.sv | 16 +
 rtl/countdown_pair_regs.sv | 34 +++
 rtl/countdown_pair.sv | 97 +++++++++
 tb/tb_countdown_pair.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/countdown_pair_pkg.sv
// Shared types and helpers for the countdown_pair block.
package countdown_pair_pkg;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // All-ones value of a w-bit counter (2^w - 1); valid for w in 1..31.
    function automatic int unsigned max_of(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/countdown_pair_regs.sv
// Complementary counter pair: v counts down, imp counts up, so that
// v + imp stays at MAX whenever both are written through this module.
module countdown_pair_regs
    import countdown_pair_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] v,
    output logic [W-1:0] imp
);

    localparam logic [W-1:0] MAX = W'(max_of(W));
    localparam logic [W-1:0] ONE = W'(1);

    // Load or step both registers together; load takes priority over step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v   <= '0;
            imp <= MAX;
        end else if (load) begin
            v   <= load_val;
            imp <= MAX - load_val;
        end else if (step) begin
            v   <= v - ONE;
            imp <= imp + ONE;
        end
    end

endmodule

// File: rtl/countdown_pair.sv
// Load/run/done countdown unit built on a complementary counter pair.
// The output is formed through both registers, so it tracks v only while
// v == MAX - imp holds.
// Optional build macro: COUNTDOWN_PAIR_INV_CHECK_EN enables a live
// invariant monitor on inv_ok plus an immediate assertion; otherwise
// inv_ok is tied high.
module countdown_pair
    import countdown_pair_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [W-1:0] load_val,
    output logic         load_ready,
    input  logic         en,
    output logic         done,
    output logic [W-1:0] out,
    output logic [W-1:0] v_o,
    output logic [W-1:0] imp_o,
    output logic         inv_ok
);

    localparam logic [W-1:0] MAX = W'(max_of(W));
    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] v;
    logic [W-1:0] imp;
    logic         load_fire;
    logic         step_fire;

    // Loads are accepted only when idle or finished; steps only while running.
    assign load_fire = load_valid && load_ready;
    assign step_fire = en && (state_q == RUN);

    countdown_pair_regs #(
        .W (W)
    ) u_regs (
        .clk      (clk),
        .rst      (rst),
        .load     (load_fire),
        .load_val (load_val),
        .step     (step_fire),
        .v        (v),
        .imp      (imp)
    );

    // State register; reset discards any in-flight count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a load of zero goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (load_valid) begin
                    state_d = (load_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (en && (v == ONE)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_ready = (state_q == IDLE) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign out        = v & (MAX - imp);
    assign v_o        = v;
    assign imp_o      = imp;

`ifdef COUNTDOWN_PAIR_INV_CHECK_EN
    assign inv_ok = (v == (MAX - imp));

    // Invariant must hold in every cycle outside reset.
    always_comb begin
        if (rst) begin
            assert (inv_ok);
        end
    end
`else
    assign inv_ok = 1'b1;
`endif

endmodule

// File: tb/tb_countdown_pair.sv
// Directed bench for countdown_pair with immediate-assertion checks.
module tb_countdown_pair;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_val;
    logic         load_ready;
    logic         en;
    logic         done;
    logic [W-1:0] out;
    logic [W-1:0] v_o;
    logic [W-1:0] imp_o;
    logic         inv_ok;

    int total;
    int bad;

    countdown_pair #(
        .W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_val   (load_val),
        .load_ready (load_ready),
        .en         (en),
        .done       (done),
        .out        (out),
        .v_o        (v_o),
        .imp_o      (imp_o),
        .inv_ok     (inv_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full observable state against expected v / done / load_ready.
    task automatic chk_state(input string tag, input int ev, input bit edone, input bit erdy);
        chk({tag, ".v"},     v_o,        ev);
        chk({tag, ".imp"},   imp_o,      15 - ev);
        chk({tag, ".out"},   out,        ev);
        chk({tag, ".done"},  done,       edone);
        chk({tag, ".rdy"},   load_ready, erdy);
        chk({tag, ".inv"},   inv_ok,     1);
    endtask

    initial begin
        int ev;
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        load_valid = 1'b0;
        load_val   = '0;
        en         = 1'b0;

        // 1: reset for two cycles, then release
        tick();
        tick();
        rst = 1'b1;
        chk_state("rst", 0, 0, 1);
        en = 1'b1;
        tick();
        chk_state("idle_en_ignored", 0, 0, 1);
        en = 1'b0;

        // 2: load 5 and count down with en held high
        load_valid = 1'b1;
        load_val   = 4'd5;
        tick();
        load_valid = 1'b0;
        chk_state("ld5", 5, 0, 0);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_state($sformatf("run5_%0d", k), 5 - k, k == 5, k == 5);
        end
        en = 1'b0;

        // 3: load 0 goes directly to DONE; en does not wrap v
        load_valid = 1'b1;
        load_val   = 4'd0;
        tick();
        load_valid = 1'b0;
        chk_state("ld0", 0, 1, 1);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_state($sformatf("done_en_%0d", k), 0, 1, 1);
        end
        en = 1'b0;

        // 4: load 9, gapped enables, mid-run load attempts are ignored
        load_valid = 1'b1;
        load_val   = 4'd9;
        tick();
        load_valid = 1'b0;
        chk_state("ld9", 9, 0, 0);
        ev = 9;
        for (int i = 0; i < 27; i++) begin
            en         = (i % 3 == 0);
            load_valid = (i == 4) || (i == 6);
            load_val   = 4'd3;
            tick();
            if (en) ev--;
            chk_state($sformatf("gap_%0d", i), ev, ev == 0, ev == 0);
        end
        en         = 1'b0;
        load_valid = 1'b0;

        // 5: load 7, three enables, then reset mid-run (reset beats load/en)
        load_valid = 1'b1;
        load_val   = 4'd7;
        tick();
        load_valid = 1'b0;
        en         = 1'b1;
        tick();
        tick();
        tick();
        chk_state("run7_3", 4, 0, 0);
        rst        = 1'b0;
        load_valid = 1'b1;
        tick();
        rst        = 1'b1;
        load_valid = 1'b0;
        en         = 1'b0;
        chk_state("midrun_rst", 0, 0, 1);

        // 6: from DONE, load 15 together with en; en not applied that cycle
        load_valid = 1'b1;
        load_val   = 4'd0;
        tick();
        chk_state("to_done", 0, 1, 1);
        load_val = 4'd15;
        en       = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_state("ld15_en", 15, 0, 0);
        tick();
        chk_state("run15_1", 14, 0, 0);
        en = 1'b0;
        tick();
        chk_state("run15_hold", 14, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
